// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the Game Boy CPU fetch/interrupt front end.
package gb_cpu_common_pkg;

  localparam int unsigned INT_COUNT = 5;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned BYTE_W    = 8;
  localparam logic [BYTE_W-1:0] ISR_VECTOR_BASE = 8'h40;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Each interrupt source owns an 8-byte slot above the vector base.
  function automatic logic [BYTE_W-1:0] isr_vector_of(input logic [IDX_W-1:0] idx);
    return ISR_VECTOR_BASE + {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/gb_cpu_int_prio.sv
// Fixed-priority interrupt encoder: the lowest set pending bit wins.
module gb_cpu_int_prio
  import gb_cpu_common_pkg::*;
(
  input  logic [INT_COUNT-1:0] pending,
  output logic                 valid,
  output logic [IDX_W-1:0]     index
);

  always_comb begin
    valid = |pending;
    index = '0;
    // Scan from the top so the lowest set bit is the final assignment.
    for (int i = INT_COUNT - 1; i >= 0; i--) begin
      if (pending[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/gb_cpu_fetch_ctrl.sv
// Instruction fetch latch with interrupt dispatch, EI delay, HALT and the halt bug.
module gb_cpu_fetch_ctrl
  import gb_cpu_common_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [BYTE_W-1:0]    data_in,
  input  logic                 cb_next,
  input  logic                 ei_req,
  input  logic                 di_req,
  input  logic                 reti_req,
  input  logic                 halt_req,
  input  logic [INT_COUNT-1:0] int_enable,
  input  logic [INT_COUNT-1:0] int_flag,
  output logic [BYTE_W-1:0]    opcode,
  output logic                 cb_prefix,
  output logic                 isr_cmd,
  output logic [BYTE_W-1:0]    isr_vector,
  output logic [INT_COUNT-1:0] int_ack,
  output logic                 ime,
  output logic                 halted,
  output logic                 pc_inc
);

  fetch_state_e state, state_nxt;

  logic                 ime_delay, ime_delay_nxt;
  logic                 halt_bug, halt_bug_nxt;
  logic [BYTE_W-1:0]    opcode_nxt;
  logic                 cb_prefix_nxt;
  logic                 isr_cmd_nxt;
  logic [BYTE_W-1:0]    isr_vector_nxt;
  logic [INT_COUNT-1:0] int_ack_nxt;
  logic                 ime_nxt;
  logic                 halted_nxt;
  logic                 pc_inc_nxt;

  logic [INT_COUNT-1:0] pending;
  logic                 pend_valid;
  logic [IDX_W-1:0]     pend_index;
  logic                 ime_eff;
  logic                 dispatch;

  assign pending = int_enable & int_flag;

  gb_cpu_int_prio u_int_prio (
    .pending (pending),
    .valid   (pend_valid),
    .index   (pend_index)
  );

  // A pending EI counts as enabled for the fetch that retires it; DI masks at once.
  assign ime_eff  = (ime | ime_delay) & ~di_req;
  assign dispatch = ime_eff & pend_valid & ~cb_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      opcode     <= '0;
      cb_prefix  <= 1'b0;
      isr_cmd    <= 1'b0;
      isr_vector <= ISR_VECTOR_BASE;
      int_ack    <= '0;
      ime        <= 1'b0;
      ime_delay  <= 1'b0;
      halted     <= 1'b0;
      pc_inc     <= 1'b1;
      halt_bug   <= 1'b0;
    end else begin
      state      <= state_nxt;
      opcode     <= opcode_nxt;
      cb_prefix  <= cb_prefix_nxt;
      isr_cmd    <= isr_cmd_nxt;
      isr_vector <= isr_vector_nxt;
      int_ack    <= int_ack_nxt;
      ime        <= ime_nxt;
      ime_delay  <= ime_delay_nxt;
      halted     <= halted_nxt;
      pc_inc     <= pc_inc_nxt;
      halt_bug   <= halt_bug_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    opcode_nxt     = opcode;
    cb_prefix_nxt  = cb_prefix;
    isr_cmd_nxt    = isr_cmd;
    isr_vector_nxt = isr_vector;
    int_ack_nxt    = '0;
    ime_nxt        = ime;
    ime_delay_nxt  = ime_delay;
    halted_nxt     = halted;
    pc_inc_nxt     = pc_inc;
    halt_bug_nxt   = halt_bug;

    if (state == ST_RUN) begin
      if (halt_req) begin
        // HALT with IME clear and an interrupt already pending falls into the halt bug.
        if (ime || !pend_valid) begin
          state_nxt  = ST_HALT;
          halted_nxt = 1'b1;
        end else begin
          halt_bug_nxt = 1'b1;
        end
      end else if (fetch_valid) begin
        if (dispatch) begin
          opcode_nxt     = '0;
          cb_prefix_nxt  = 1'b0;
          isr_cmd_nxt    = 1'b1;
          isr_vector_nxt = isr_vector_of(pend_index);
          pc_inc_nxt     = 1'b0;
          int_ack_nxt    = INT_COUNT'(1) << pend_index;
          ime_nxt        = 1'b0;
          ime_delay_nxt  = 1'b0;
        end else begin
          opcode_nxt    = data_in;
          cb_prefix_nxt = cb_next;
          isr_cmd_nxt   = 1'b0;
          pc_inc_nxt    = ~halt_bug;
          halt_bug_nxt  = 1'b0;
          if (ime_delay) begin
            ime_nxt       = 1'b1;
            ime_delay_nxt = 1'b0;
          end
        end
      end
    end else if (pend_valid) begin
      state_nxt  = ST_RUN;
      halted_nxt = 1'b0;
    end

    // Sequencer pulses applied last so DI overrides EI and RETI.
    if (ei_req)   ime_delay_nxt = 1'b1;
    if (reti_req) ime_nxt       = 1'b1;
    if (di_req) begin
      ime_nxt       = 1'b0;
      ime_delay_nxt = 1'b0;
    end
  end

endmodule

// File: doc/gb_cpu_fetch_ctrl.md
GB_CPU_FETCH_CTRL -- requirements
Module: gb_cpu_fetch_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 fetch_valid  in  1  final cycle of current instruction; data_in holds the next opcode byte.
REQ-004 data_in  in  8  opcode byte from the memory bus.
REQ-005 cb_next  in  1  current instruction is the 0xCB prefix; the next byte is a CB opcode.
REQ-006 ei_req / di_req / reti_req / halt_req  in  1 each  single-cycle execution pulses from the sequencer.
REQ-007 int_enable  in  5  IE register bits [4:0].
REQ-008 int_flag  in  5  IF register bits [4:0].
REQ-009 opcode  out  8  latched instruction byte to the decoder.
REQ-010 cb_prefix  out  1  latched CB-prefix qualifier to the decoder.
REQ-011 isr_cmd  out  1  next schedule is interrupt dispatch.
REQ-012 isr_vector  out  8  dispatch address, 0x40 + 8*index.
REQ-013 int_ack  out  5  one-hot, one-cycle pulse that clears the serviced IF bit.
REQ-014 ime  out  1  interrupt master enable.
REQ-015 halted  out  1  core is in HALT.
REQ-016 pc_inc  out  1  PC increments for the latched fetch; 0 on ISR dispatch or halt bug.

Function
REQ-017 pending = int_enable & int_flag; index = lowest set bit, so bit0 has highest priority.
REQ-018 States: RUN, HALT. Dispatch is a registered qualifier inside RUN, not a separate state.
REQ-019 RUN, fetch_valid=1: latch one of two cases on that edge.
  - No dispatch: latch opcode<=data_in, cb_prefix<=cb_next, isr_cmd<=0, pc_inc<=1.
REQ-020 Dispatch condition is ime_eff & |pending & ~cb_next, where ime_eff = (ime | ime_delay) & ~di_req.
  - On dispatch: isr_cmd<=1, opcode<=0x00, cb_prefix<=0, pc_inc<=0, isr_vector<=0x40+8*index.
  - Same edge: int_ack<=onehot(index) for exactly one cycle; ime<=0; ime_delay<=0.
REQ-021 cb_next=1 always suppresses dispatch; an interrupt never splits the CB prefix from its operand.
REQ-022 ei_req sets ime_delay on the next edge. At the next fetch_valid with ime_delay=1: ime<=1, ime_delay<=0, and that fetch's check treats IME as 1. This gives exactly one instruction after EI before an interrupt can be taken.
REQ-023 di_req clears ime and ime_delay on the next edge and masks dispatch in the same cycle.
REQ-024 reti_req sets ime<=1 immediately, with no delay.
REQ-025 halt_req in RUN, two cases.
  - ime=1 or pending=0: go to HALT, halted<=1.
  - ime=0 and pending!=0 (halt bug): stay in RUN and set halt_bug; the next non-dispatch fetch latches pc_inc<=0, then halt_bug clears.
REQ-026 HALT: fetch_valid is ignored and outputs hold. When pending!=0, regardless of ime, go to RUN and set halted<=0 on the next edge.
REQ-027 Simultaneous requests:
  - di_req and ei_req together: DI wins.
  - halt_req and fetch_valid together: halt_req wins; no latch.
REQ-028 With fetch_valid=0 in RUN, opcode, cb_prefix, isr_cmd and isr_vector hold.

Reset
REQ-029 While reset=1, outputs take these values:
  - opcode=0x00, cb_prefix=0, isr_cmd=0, isr_vector=0x40, int_ack=0, ime=0, halted=0, pc_inc=1.
  - Internal: ime_delay=0, halt_bug=0, state=RUN.
REQ-030 Reset during HALT or a pending dispatch abandons it; no int_ack pulse is emitted.

Structure
REQ-031 gb_cpu_common_pkg holds the fetch state enum, INT_COUNT=5 and ISR_VECTOR_BASE=8'h40.
REQ-032 Priority encoding lives in sub-module gb_cpu_int_prio (pending[4:0] -> valid, index[2:0]).
REQ-033 All outputs are registered; no combinational path from data_in to any output.

Verification
REQ-034 Reset, then fetch_valid with data_in=0x3E: opcode=0x3E, cb_prefix=0, isr_cmd=0, pc_inc=1.
REQ-035 ime=1, IE=0x1F, IF=0x14 at fetch_valid: isr_cmd=1, isr_vector=0x50, int_ack=0x04 for one cycle, ime=0, pc_inc=0.
REQ-036 EI then fetch of X with IE=IF=0x01: X latched without dispatch; next fetch_valid dispatches to 0x40.
REQ-037 cb_next=1 with ime=1 and pending=0x01: next latch is the CB opcode with cb_prefix=1; dispatch occurs at the following fetch.
REQ-038 halt_req with ime=0 and IF=0: halted=1. Then raise IE=IF=0x02: halted=0, and the next fetch latches normally with isr_cmd=0.
REQ-039 halt_req with ime=0 and IE=IF=0x01: halted stays 0; next fetch has pc_inc=0, the fetch after has pc_inc=1.
